// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Debug console transmitter. Bytes written by the upstream producer are
// buffered in a small circular FIFO and serialized as 8N1 UART frames
// (start bit, 8 data bits LSB first, one stop bit) at a fixed baud divisor.
//
// Parameters:
//   CLK_DIV  clock cycles per UART bit (2..65535)
//   FIFO_AW  FIFO address width; depth = 2**FIFO_AW
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       asynchronous active-low reset
//   wr_en     write strobe, sampled every clock
//   wr_data   byte to enqueue when wr_en=1
//   clr_ovf   synchronous clear of the overflow flag
//   full      FIFO holds 2**FIFO_AW bytes
//   empty     FIFO holds no bytes
//   count     number of bytes currently queued
//   overflow  sticky flag: a write was dropped because the FIFO was full
//   busy      serializer is outside IDLE
//   tx        serial line, idle high, driven from a register
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLK_DIV = 87,
   parameter int FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [7:0]         wr_data,
   input  logic               clr_ovf,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   count,
   output logic               overflow,
   output logic               busy,
   output logic               tx
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CNT_W = FIFO_AW + 1;
   localparam int CW    = $clog2(CLK_DIV);

   localparam logic [CW-1:0]      DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]      BIT_ONE   = CW'(1);
   localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               overflow_reg;

   // Serializer state
   state_t             state_reg;
   state_t             state_next;
   logic [CW-1:0]      bit_cnt_reg;
   logic [CW-1:0]      bit_cnt_next;
   logic [2:0]         bit_idx_reg;
   logic [2:0]         bit_idx_next;
   logic [7:0]         shift_reg;
   logic               tx_reg;
   logic               tx_next;

   logic               push;
   logic               pop;
   logic               shift_en;
   logic               bit_last;
   logic               full_int;
   logic               empty_int;

   // Flags come from the registered count only, never from the pointers.
   assign full_int  = (count_reg == DEPTH_CNT);
   assign empty_int = (count_reg == '0);

   // A write is accepted purely on the registered full flag, so a pop in the
   // same cycle neither rescues a write to a full FIFO nor blocks one otherwise.
   assign push     = wr_en & ~full_int;
   assign bit_last = (bit_cnt_reg == DIV_LAST);

   // ---------------------------------------------------------------------
   // FIFO storage: plain array written without reset so it maps to RAM.
   // The read side is registered by loading the shift register on a pop.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------
   // Serializer next-state logic. tx_next is the line level for the state
   // being entered, so the registered tx lines up with state_reg.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_last ? '0 : (bit_cnt_reg + BIT_ONE);
      bit_idx_next = bit_idx_reg;
      pop          = 1'b0;
      shift_en     = 1'b0;
      tx_next      = 1'b1;

      case (state_reg)
         IDLE: begin
            bit_cnt_next = '0;
            if (!empty_int) begin
               pop        = 1'b1;
               state_next = START;
               tx_next    = 1'b0;
            end
         end

         START: begin
            tx_next = 1'b0;
            if (bit_last) begin
               state_next   = DATA;
               bit_idx_next = 3'd0;
               tx_next      = shift_reg[0];
            end
         end

         DATA: begin
            tx_next = shift_reg[0];
            if (bit_last) begin
               shift_en = 1'b1;
               if (bit_idx_reg == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
                  // shift_reg shifts on this edge, so the next bit is [1]
                  tx_next      = shift_reg[1];
               end
            end
         end

         STOP: begin
            tx_next = 1'b1;
            if (bit_last) begin
               if (!empty_int) begin
                  // Chain straight into the next frame with no idle gap.
                  pop        = 1'b1;
                  state_next = START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = IDLE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers. Reset truncates any frame in flight with tx high.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= '0;
         bit_idx_reg  <= 3'd0;
         shift_reg    <= 8'h00;
         tx_reg       <= 1'b1;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         bit_idx_reg <= bit_idx_next;
         tx_reg      <= tx_next;

         if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
         end else if (shift_en) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
         end

         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase

         // A dropped write takes priority over a clear in the same cycle.
         if (wr_en && full_int) begin
            overflow_reg <= 1'b1;
         end else if (clr_ovf) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   assign full     = full_int;
   assign empty    = empty_int;
   assign count    = count_reg;
   assign overflow = overflow_reg;
   assign busy     = (state_reg != IDLE);
   assign tx       = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Two instances: dut_a with CLK_DIV=4, dut_b with CLK_DIV=2. Stimulus pushes
// the bytes it expects on the line into a queue; a UART receiver monitor
// decodes frames from the selected tx line and compares each against the
// queue head. Flag and timing checks are made directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int DIV_A = 4;
   localparam int DIV_B = 2;

   logic       clk = 1'b0;
   logic       rst;

   logic       wr_en_a, clr_ovf_a;
   logic [7:0] wr_data_a;
   logic       full_a, empty_a, overflow_a, busy_a, tx_a;
   logic [4:0] count_a;

   logic       wr_en_b, clr_ovf_b;
   logic [7:0] wr_data_b;
   logic       full_b, empty_b, overflow_b, busy_b, tx_b;
   logic [4:0] count_b;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLK_DIV(DIV_A), .FIFO_AW(4)) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a),
      .clr_ovf(clr_ovf_a), .full(full_a), .empty(empty_a), .count(count_a),
      .overflow(overflow_a), .busy(busy_a), .tx(tx_a)
   );

   uart_tx_fifo #(.CLK_DIV(DIV_B), .FIFO_AW(4)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b),
      .clr_ovf(clr_ovf_b), .full(full_b), .empty(empty_b), .count(count_b),
      .overflow(overflow_b), .busy(busy_b), .tx(tx_b)
   );

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];
   int         cyc = 0;
   bit         sel = 1'b0;   // 0: monitor dut_a, 1: monitor dut_b

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- UART receiver monitor ----------------
   bit         mon_active = 1'b0;
   int         mon_cnt    = 0;
   int         mon_div;
   logic       tx_m;
   logic [7:0] mon_byte;

   always @(negedge clk) begin
      cyc++;
      tx_m    = sel ? tx_b : tx_a;
      mon_div = sel ? DIV_B : DIV_A;
      if (!rst) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx_m == 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            start_q.push_back(cyc);
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == mon_div / 2) check("start_bit", tx_m, 1'b0);
         for (int i = 0; i < 8; i++) begin
            if (mon_cnt == mon_div * (1 + i) + mon_div / 2) mon_byte[i] = tx_m;
         end
         if (mon_cnt == 9 * mon_div + mon_div / 2) begin
            check("stop_bit", tx_m, 1'b1);
            if (exp_q.size() == 0) begin
               check("unexpected_frame", {24'd0, mon_byte}, 32'hFFFF_FFFF);
            end else begin
               check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
            end
            $display("[cyc %0d] dut_%s frame byte=%02h", cyc, sel ? "b" : "a", mon_byte);
            mon_active = 1'b0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_busy_low(input bit s, input int limit, output int n);
      n = 0;
      while (((s ? busy_b : busy_a) == 1'b1) && (n < limit)) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int gap;

      rst = 1'b0;
      wr_en_a = 0; clr_ovf_a = 0; wr_data_a = 0;
      wr_en_b = 0; clr_ovf_b = 0; wr_data_b = 0;
      tick(3);

      // reset state
      check("rst_tx", tx_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_count", count_a, 5'd0);
      check("rst_empty", empty_a, 1'b1);
      check("rst_full", full_a, 1'b0);
      check("rst_ovf", overflow_a, 1'b0);
      check("rst_tx_b", tx_b, 1'b1);

      rst = 1'b1;
      tick(2);

      // single byte 0x55
      wr_data_a = 8'h55; wr_en_a = 1'b1; exp_q.push_back(8'h55);
      tick(1);
      wr_en_a = 1'b0;
      check("single_count_after_write", count_a, 5'd1);
      check("single_tx_before_pop", tx_a, 1'b1);
      check("single_busy_before_pop", busy_a, 1'b0);
      tick(1);
      check("single_tx_start", tx_a, 1'b0);
      check("single_busy_start", busy_a, 1'b1);
      check("single_empty_after_pop", empty_a, 1'b1);
      wait_busy_low(0, 200, n);
      check("single_busy_len", n, 40);
      check("single_tx_idle", tx_a, 1'b1);
      check("single_empty_end", empty_a, 1'b1);
      check("single_frames_seen", exp_q.size(), 0);

      // back-to-back 0xA3, 0x0F
      tick(3);
      start_q.delete();
      wr_data_a = 8'hA3; wr_en_a = 1'b1; exp_q.push_back(8'hA3);
      tick(1);
      wr_data_a = 8'h0F; exp_q.push_back(8'h0F);
      tick(1);
      wr_en_a = 1'b0;
      check("b2b_push_pop_count", count_a, 5'd1);
      check("b2b_busy", busy_a, 1'b1);
      wait_busy_low(0, 300, n);
      check("b2b_busy_len", n, 80);
      check("b2b_frames", start_q.size(), 2);
      gap = (start_q.size() >= 2) ? (start_q[1] - start_q[0]) : -1;
      check("b2b_start_gap", gap, 40);
      check("b2b_queue_empty", exp_q.size(), 0);

      // overflow: 0x00..0x11 on 18 consecutive edges
      tick(3);
      for (int i = 0; i < 18; i++) begin
         wr_data_a = i[7:0];
         wr_en_a   = 1'b1;
         if (i < 17) exp_q.push_back(i[7:0]);
         tick(1);
         if (i == 16) begin
            check("ovf_count_full", count_a, 5'd16);
            check("ovf_full_flag", full_a, 1'b1);
            check("ovf_not_yet", overflow_a, 1'b0);
         end
      end
      wr_en_a = 1'b0;
      check("ovf_set", overflow_a, 1'b1);
      check("ovf_count_held", count_a, 5'd16);
      clr_ovf_a = 1'b1;
      tick(1);                                  // edge 19
      clr_ovf_a = 1'b0;
      check("ovf_cleared", overflow_a, 1'b0);
      tick(22);                                 // edge 41
      check("drain_pre_count", count_a, 5'd16);
      check("drain_pre_full", full_a, 1'b1);
      // edge 42: STOP of the first frame pops; write while full is dropped
      // and a coincident clear loses to the set
      wr_data_a = 8'hEE; wr_en_a = 1'b1; clr_ovf_a = 1'b1;
      tick(1);
      wr_en_a = 1'b0; clr_ovf_a = 1'b0;
      check("drain_ovf_set_wins", overflow_a, 1'b1);
      check("drain_count", count_a, 5'd15);
      check("drain_full_clear", full_a, 1'b0);
      clr_ovf_a = 1'b1;
      tick(1);
      clr_ovf_a = 1'b0;
      check("drain_ovf_cleared", overflow_a, 1'b0);
      wait_busy_low(0, 1000, n);
      check("drain_finished", (n < 1000), 1'b1);
      check("drain_empty", empty_a, 1'b1);
      check("drain_queue_empty", exp_q.size(), 0);

      // reset during DATA bit 3 of 0xC6 (bit 3 = 0, so tx is low there)
      tick(3);
      wr_data_a = 8'hC6; wr_en_a = 1'b1; exp_q.push_back(8'hC6);
      tick(1);
      wr_data_a = 8'h3C; exp_q.push_back(8'h3C);
      tick(1);
      wr_en_a = 1'b0;
      tick(16);
      check("midrst_busy_before", busy_a, 1'b1);
      check("midrst_tx_before", tx_a, 1'b0);
      check("midrst_count_before", count_a, 5'd1);
      rst = 1'b0;
      #1;
      check("midrst_tx", tx_a, 1'b1);
      check("midrst_busy", busy_a, 1'b0);
      check("midrst_count", count_a, 5'd0);
      check("midrst_empty", empty_a, 1'b1);
      exp_q.delete();
      start_q.delete();
      tick(2);
      rst = 1'b1;
      tick(100);
      check("midrst_no_residual", start_q.size(), 0);
      check("midrst_idle", busy_a, 1'b0);

      // CLK_DIV=2 with 0x80
      sel = 1'b1;
      tick(2);
      start_q.delete();
      wr_data_b = 8'h80; wr_en_b = 1'b1; exp_q.push_back(8'h80);
      tick(1);
      wr_en_b = 1'b0;
      tick(1);
      check("div2_tx_start", tx_b, 1'b0);
      check("div2_busy", busy_b, 1'b1);
      wait_busy_low(1, 100, n);
      check("div2_frame_len", n, 20);
      check("div2_tx_idle", tx_b, 1'b1);
      check("div2_frames", start_q.size(), 1);
      check("div2_queue_empty", exp_q.size(), 0);

      tick(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Debug console transmitter that consumes the byte stream produced by `top`. It sits directly downstream of `top` and drives the board's serial TX pin.
- Bytes written by `top` are buffered in a small FIFO, then serialized as 8N1 UART frames (LSB first) at a fixed baud divisor.
- Gives the simulation bench and the hardware a single observable character output.

Parameters:
- CLK_DIV, 87, clock cycles per UART bit; legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16 by default).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe from `top`; sampled every clock.
- wr_data  in  8  byte to enqueue when wr_en=1.
- clr_ovf  in  1  clears the overflow flag; synchronous.
- full  out  1  FIFO holds 2**FIFO_AW bytes (registered count).
- empty  out  1  FIFO holds 0 bytes (registered count).
- count  out  FIFO_AW+1  number of bytes currently queued.
- overflow  out  1  sticky flag: a write was dropped.
- busy  out  1  high while the serializer is outside IDLE.
- tx  out  1  serial line, idle high.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, busy=0, count=0, empty=1, full=0, overflow=0.
  - State forced to IDLE and FIFO pointers cleared, including mid-frame. A partial frame is simply truncated with tx held high.
- FIFO:
  - Circular buffer; read/write pointers are FIFO_AW bits and wrap naturally.
  - count is a registered up/down counter. full and empty decode from the registered count only.
  - Write accepted iff wr_en=1 and full=0.
  - A write when full=0 is accepted even if a pop occurs in the same cycle.
  - A write when full=1 is dropped even if a pop occurs in the same cycle, and sets overflow.
  - Simultaneous accepted write and pop: count is unchanged.
  - overflow stays 1 until clr_ovf=1. If clr_ovf coincides with a dropped write, overflow stays set (set wins).
- Serializer FSM: IDLE, START, DATA, STOP.
  - Bit counter: 0..CLK_DIV-1. Data bit index: 0..7.
  - IDLE: tx=1. If empty=0, pop the head byte into the shift register and go to START. No fall-through: a byte written into an empty FIFO at edge k is popped at edge k+1, and tx=0 after edge k+1.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for CLK_DIV cycles per bit, shifting right between bits. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. On its last cycle:
    - if empty=0, pop and go directly to START (zero inter-frame gap);
    - otherwise go to IDLE.
  - Frame length: exactly 10*CLK_DIV cycles.
- busy=1 in START, DATA and STOP. tx is driven from a register (no combinational glitches).

Test Plan:
- Single byte, CLK_DIV=4: after reset, write 0x55 at edge 1 -> tx falls after edge 2. tx then reads 0,1,0,1,0,1,0,1,0,1, each bit lasting 4 cycles. busy=1 for 40 cycles, then tx=1, empty=1.
- Back-to-back, CLK_DIV=4: write 0xA3 then 0x0F on consecutive cycles -> two frames with no idle gap. Start bit of 0x0F begins exactly 40 cycles after the first start bit. Data bits LSB first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- Overflow, CLK_DIV=4: write 0x00..0x11 on 18 consecutive edges -> count=16 and full=1 after edge 17. Byte 0x11 is dropped and overflow=1. Byte 0x00 is transmitted first; clr_ovf pulse -> overflow=0.
- Drain with write while full: FIFO full and STOP ending with a pop; wr_en at that same edge -> write dropped, overflow=1, count=15.
- Reset mid-frame: assert rst=0 during DATA bit 3 -> tx=1, busy=0, count=0 immediately (before the next clock). After release, no residual frame is sent.
- Divider extremes: CLK_DIV=2 and 0x80 -> start bit 2 cycles, bits 0..6 low, bit 7 high, stop high, frame length 20 cycles.
